// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Nibble counter width; at least one bit so a single-nibble build still has a counter.
  function automatic int unsigned cnt_w(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is flattened from generate/propagate terms; no ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit: one shared 4-bit CLA slice, one nibble per cycle, LSB first.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = cnt_w(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] work_next;

  // Select nibble k of the latched operands and merge the slice sum back into the working word.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    work_next = work_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == CNT_W'(i)) begin
        slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        slice_b = b_q[i*NIBBLE_W +: NIBBLE_W];
        work_next[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
      end
    end
  end

  cla_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d  = work_next;
        carry_d = slice_cout;
        if (k_q == LAST_K) begin
          state_d  = StDone;
          result_d = work_next;
          cout_d   = slice_cout;
          ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_next[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder at WIDTH = 16: vector table plus handshake corner cases.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from idle or done, then check latency, busy profile and outputs.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    start = 1'b1;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    tick();
    start = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " busy during done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, 32'(result), 32'(v.res));
    chk({tag, " cout"}, 32'(cout), 32'(v.cout));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
  endtask

  initial begin
    vec_t   q[3];
    logic   seen;
    logic [15:0] prev;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Start re-asserted with other operands during RUN must be ignored.
    prev = result;
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FFF;
    tick();
    a = 16'h0101; b = 16'h0202; sub = 1'b1;
    for (int c = 1; c < 4; c++) begin
      tick();
      chk($sformatf("ign done low c%0d", c), 32'(done), 32'd0);
      chk($sformatf("ign result held c%0d", c), 32'(result), 32'(prev));
    end
    tick();
    start = 1'b0;
    chk("ign done", 32'(done), 32'd1);
    chk("ign result", 32'(result), 32'h2233);
    tick();
    chk("ign no restart", 32'(busy), 32'd0);

    // Start held high; new operands presented in each done cycle.
    q[0] = vecs[2]; q[1] = vecs[4]; q[2] = vecs[8];
    start = 1'b1; sub = q[0].sub; a = q[0].a; b = q[0].b;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = 16'hDEAD; b = 16'hBEEF; sub = ~q[i].sub;
      for (int c = 1; c < 4; c++) begin
        tick();
        chk($sformatf("b2b%0d done low c%0d", i, c), 32'(done), 32'd0);
      end
      tick();
      chk($sformatf("b2b%0d done", i), 32'(done), 32'd1);
      chk($sformatf("b2b%0d result", i), 32'(result), 32'(q[i].res));
      chk($sformatf("b2b%0d cout", i), 32'(cout), 32'(q[i].cout));
      chk($sformatf("b2b%0d ovf", i), 32'(ovf), 32'(q[i].ovf));
      if (i < 2) begin
        sub = q[i+1].sub; a = q[i+1].a; b = q[i+1].b;
      end else begin
        start = 1'b0;
      end
      tick();
      chk($sformatf("b2b%0d busy next", i), 32'(busy), (i < 2) ? 32'd1 : 32'd0);
    end

    // Reset on the second RUN cycle abandons the operation.
    start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | done | busy;
    end
    chk("rst no done", 32'(seen), 32'd0);
    run_op(vecs[0], "after rst");
    tick();

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0001;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst+start busy", 32'(busy), 32'd0);
    chk("rst+start result", 32'(result), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
